// File: rtl/sysdef_pkg.sv
// Shared AES datapath types: packets exchanged with the FIFOs and aes_engine,
// plus the issue-scheduler state encoding.
package sysdef;

  localparam int AES_PKT_W = 131;

  typedef struct packed {
    logic         valid;
    logic         set_key;
    logic         encrypt;
    logic [127:0] data;
  } in_packet_t;

  typedef struct packed {
    logic         valid;
    logic [127:0] data;
  } out_packet_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, KEYWAIT} sched_state_t;

endpackage

// File: rtl/aes_credit_counter.sv
// Up/down occupancy counter; decrements at zero are ignored so it never wraps low.
module aes_credit_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         dec_eff;

  assign dec_eff = dec_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_eff)      cnt_d = cnt_q + W'(1);
    else if (dec_eff && !inc_i) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_job_scheduler.sv
// Issue controller between the input packet FIFO and aes_engine: forwards jobs,
// serialises key loads and holds back data when output credit runs out.
module aes_job_scheduler
  import sysdef::*;
#(
  parameter int PIPE_DEPTH = 16,
  parameter int KEY_LAT    = 11,
  parameter int CNT_W      = 6,
  parameter int STAT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [AES_PKT_W-1:0] fifo_head,
  output logic                 fifo_rd_en,
  input  logic                 eng_load_data,
  output logic [AES_PKT_W-1:0] eng_data_in,
  input  logic                 eng_out_valid,
  input  logic [CNT_W-1:0]     out_free,
  output logic                 key_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     inflight,
  output logic                 err_no_key,
  output logic [STAT_W-1:0]    jobs_issued,
  output logic [STAT_W-1:0]    jobs_done
);

  localparam int KC_W = $clog2(KEY_LAT + 1);

  in_packet_t      head;
  sched_state_t    state_q, state_d;
  logic            key_valid_q, key_valid_d;
  logic [KC_W-1:0] kcnt_q, kcnt_d;
  in_packet_t      eng_q, eng_d;
  logic [STAT_W-1:0] issued_q, done_q;
  logic            fwd, key_pop, drop, data_ok;

  assign head = in_packet_t'(fifo_head);

  assign data_ok = enable && !fifo_empty && eng_load_data &&
                   (inflight < CNT_W'(PIPE_DEPTH)) && (inflight < out_free);

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    kcnt_d      = kcnt_q;
    fwd         = 1'b0;
    key_pop     = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: if (enable && !fifo_empty) state_d = RUN;
      RUN: begin
        if (!enable || fifo_empty) state_d = IDLE;
        else if (head.set_key)     state_d = DRAIN;
        else if (!key_valid_q)     drop    = 1'b1;
        else if (data_ok)          fwd     = 1'b1;
      end
      DRAIN: begin
        // The engine must be empty so no data runs under a half-loaded key.
        if (enable && !fifo_empty && eng_load_data && inflight == '0) begin
          key_pop     = 1'b1;
          key_valid_d = 1'b0;
          kcnt_d      = '0;
          state_d     = KEYWAIT;
        end
      end
      KEYWAIT: begin
        if (kcnt_q == KC_W'(KEY_LAT - 1)) begin
          key_valid_d = 1'b1;
          state_d     = RUN;
        end else begin
          kcnt_d = kcnt_q + KC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eng_d = '0;
    if (fwd || key_pop) begin
      eng_d       = head;
      eng_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      kcnt_q      <= '0;
      eng_q       <= '0;
      issued_q    <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      kcnt_q      <= kcnt_d;
      eng_q       <= eng_d;
      if (fwd)           issued_q <= issued_q + STAT_W'(1);
      if (eng_out_valid) done_q   <= done_q + STAT_W'(1);
    end
  end

  aes_credit_counter #(.W(CNT_W)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fwd),
    .dec_i (eng_out_valid),
    .cnt_o (inflight)
  );

  assign fifo_rd_en  = (fwd || key_pop || drop) && !fifo_empty;
  assign eng_data_in = eng_q;
  assign key_valid   = key_valid_q;
  assign busy        = (state_q != IDLE) || (inflight != '0);
  assign err_no_key  = drop;
  assign jobs_issued = issued_q;
  assign jobs_done   = done_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler: a FIFO model and an engine model feed
// the DUT, and a negedge monitor checks every packet issued to the engine.
module tb_aes_job_scheduler;
  import sysdef::*;

  localparam int KEY_LAT = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         enable = 1'b0, eng_load_data = 1'b0;
  logic         fifo_empty, fifo_rd_en, eng_out_valid;
  logic         key_valid, busy, err_no_key;
  logic [130:0] fifo_head, eng_data_in;
  logic [5:0]   out_free = 6'd8;
  logic [5:0]   inflight;
  logic [31:0]  jobs_issued, jobs_done;

  aes_job_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_head(fifo_head), .fifo_rd_en(fifo_rd_en), .eng_load_data(eng_load_data),
    .eng_data_in(eng_data_in), .eng_out_valid(eng_out_valid), .out_free(out_free),
    .key_valid(key_valid), .busy(busy), .inflight(inflight), .err_no_key(err_no_key),
    .jobs_issued(jobs_issued), .jobs_done(jobs_done)
  );

  // input FIFO model, first-word fall-through
  logic [130:0] mem [64];
  int   rd = 0, wr = 0;
  logic flush = 1'b0;
  assign fifo_empty = (rd == wr);
  assign fifo_head  = mem[rd % 64];
  always @(posedge clk) if (flush) rd <= wr; else if (fifo_rd_en) rd <= rd + 1;

  // engine model: data results return ret_lat cycles after issue
  logic [31:0] ret_sr;
  int   ret_lat = 5;
  logic auto_ret = 1'b0, man_ret = 1'b0, sim_ret = 1'b0;
  in_packet_t eng_pkt;
  assign eng_pkt = in_packet_t'(eng_data_in);
  always @(posedge clk or posedge rst)
    if (rst) ret_sr <= '0;
    else     ret_sr <= {ret_sr[30:0], eng_pkt.valid & ~eng_pkt.set_key};
  assign eng_out_valid = (auto_ret & ret_sr[ret_lat-1]) | man_ret | (sim_ret & fifo_rd_en);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  logic [130:0] expq [$];
  int   n_d, n_err, first_d, last_d, post_d, key_iss, key_inf, kv_rise, max_inf;
  logic kv_prev = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_d = 0; n_err = 0; first_d = -1; last_d = -1; post_d = -1;
    key_iss = -1; key_inf = -1; kv_rise = -1; max_inf = 0;
  endtask

  task automatic push(logic sk, logic [127:0] d, logic expect_issue);
    in_packet_t p;
    p.valid = 1'b1; p.set_key = sk; p.encrypt = 1'b1; p.data = d;
    mem[wr % 64] = p;
    wr++;
    if (expect_issue) expq.push_back(p);
  endtask

  task automatic wait_sb(string name, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (rd == wr && expq.size() == 0) break;
    end
    chk({name, "_timeout"}, (i < budget) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic retire(int n);
    man_ret = 1'b1;
    repeat (n) @(posedge clk);
    #1 man_ret = 1'b0;
  endtask

  // monitor: scoreboard compare plus timing capture
  always @(negedge clk) begin
    logic [130:0] e;
    if (!rst) begin
      if (eng_pkt.valid) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h", eng_data_in);
        end else begin
          e = expq.pop_front();
          if (eng_data_in !== e) begin
            bad++;
            $display("FAIL sb_pkt got=%h exp=%h", eng_data_in, e);
          end
        end
        if (eng_pkt.set_key) begin
          key_iss = cyc; key_inf = int'(inflight);
        end else begin
          n_d++;
          if (first_d < 0) first_d = cyc;
          last_d = cyc;
          if (key_iss >= 0 && post_d < 0) post_d = cyc;
        end
      end
      if (err_no_key) n_err++;
      if (key_valid && !kv_prev) kv_rise = cyc;
      kv_prev = key_valid;
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
    end
  end

  initial begin
    clear_stats();
    enable = 1'b1; eng_load_data = 1'b1; out_free = 6'd8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_eng_nonzero", |eng_data_in, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_jobs_issued", jobs_issued, 0);
    @(posedge clk); #1 rst = 1'b0;

    // missing key: data dropped with an error pulse
    clear_stats();
    push(1'b0, 128'hdead, 1'b0);
    wait_sb("nokey", 40);
    chk("nokey_err", n_err, 1);
    chk("nokey_issued", n_d, 0);
    chk("nokey_inflight", inflight, 0);
    chk("nokey_jobs", jobs_issued, 0);

    // key then 4 data, results held back
    clear_stats();
    push(1'b1, 128'h4b4b, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 128'h100 + 128'(i), 1'b1);
    wait_sb("kd", 100);
    chk("kd_kv_lat", kv_rise - key_iss, KEY_LAT);
    chk("kd_first_data", post_d - key_iss, KEY_LAT + 1);
    chk("kd_back_to_back", last_d - first_d, 3);
    chk("kd_ndata", n_d, 4);
    chk("kd_peak", max_inf, 4);
    chk("kd_jobs", jobs_issued, 4);
    chk("kd_key_valid", key_valid, 1);
    retire(4);
    chk("kd_drained", inflight, 0);
    chk("kd_done", jobs_done, 4);

    // key mid-stream with 5-cycle engine returns
    clear_stats();
    auto_ret = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 128'h200 + 128'(i), 1'b1);
    push(1'b1, 128'h4c4c, 1'b1);
    for (int i = 0; i < 2; i++) push(1'b0, 128'h300 + 128'(i), 1'b1);
    wait_sb("mid", 150);
    repeat (8) @(posedge clk);
    #1 auto_ret = 1'b0;
    chk("mid_inf_at_key", key_inf, 0);
    chk("mid_post_data", post_d - key_iss, KEY_LAT + 1);
    chk("mid_kv_lat", kv_rise - key_iss, KEY_LAT);
    chk("mid_ndata", n_d, 5);
    chk("mid_inflight", inflight, 0);

    // credit stall with out_free=2
    clear_stats();
    out_free = 6'd2;
    for (int i = 0; i < 6; i++) push(1'b0, 128'h400 + 128'(i), 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("cr_stall_n", n_d, 2);
    chk("cr_stall_inf", inflight, 2);
    retire(1);
    repeat (6) @(posedge clk);
    #1;
    chk("cr_resume_n", n_d, 3);
    chk("cr_resume_inf", inflight, 2);
    out_free = 6'd8;
    wait_sb("cr", 60);
    chk("cr_all_n", n_d, 6);
    chk("cr_all_inf", inflight, 5);
    retire(2);
    chk("sim_pre_inf", inflight, 3);

    // simultaneous issue and retire
    sim_ret = 1'b1;
    push(1'b0, 128'h500, 1'b1);
    wait_sb("sim", 40);
    sim_ret = 1'b0;
    chk("sim_inf", inflight, 3);
    chk("sim_done", jobs_done, 13);
    retire(3);
    chk("tot_issued", jobs_issued, 16);
    chk("tot_done", jobs_done, 16);
    chk("tot_busy", busy, 0);

    // reset while waiting to load a key with two jobs in flight
    clear_stats();
    push(1'b0, 128'h600, 1'b1);
    push(1'b0, 128'h601, 1'b1);
    push(1'b1, 128'h4d4d, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("rm_pre_inf", inflight, 2);
    chk("rm_pre_busy", busy, 1);
    chk("rm_pre_kv", key_valid, 1);
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("rm_inf", inflight, 0);
    chk("rm_kv", key_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_jobs", jobs_issued, 0);
    chk("rm_expq", expq.size(), 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_stats();
    push(1'b0, 128'h700, 1'b0);
    wait_sb("rm_post", 40);
    chk("rm_post_err", n_err, 1);
    chk("rm_post_ndata", n_d, 0);
    chk("rm_post_inf", inflight, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
